// File: rtl/accel_poll_sequencer_if.sv
// Byte-level SPI master handshake: sequencer issues bytes (master), SPI engine executes them (slave).
interface accel_poll_sequencer_if;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_rx_byte;
  logic       spi_start;
  logic [7:0] spi_tx_byte;
  logic       spi_hold;

  modport master (
    input  spi_busy, spi_done, spi_rx_byte,
    output spi_start, spi_tx_byte, spi_hold
  );

  modport slave (
    input  spi_start, spi_tx_byte, spi_hold,
    output spi_busy, spi_done, spi_rx_byte
  );
endinterface

// File: rtl/accel_poll_sequencer.sv
// Accelerometer SPI sequencer: config write after reset, then periodic 7-byte burst read of X/Y/Z.
// sample_valid one cycle after the last byte; each byte waits for spi_busy low and then for spi_done.
module accel_poll_sequencer #(
  parameter int         POLL_DIV  = 1000,
  parameter logic [7:0] CFG_ADDR  = 8'h20,
  parameter logic [7:0] CFG_DATA  = 8'h47,
  parameter logic [7:0] DATA_ADDR = 8'h28
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          reconfig,
  accel_poll_sequencer_if.master        spi,
  output logic [15:0]                   accel_x,
  output logic [15:0]                   accel_y,
  output logic [15:0]                   accel_z,
  output logic                          sample_valid,
  output logic                          cfg_done,
  output logic                          overrun
);

  localparam int             CW          = $clog2(POLL_DIV);
  localparam logic [CW-1:0]  CNT_MAX     = CW'(POLL_DIV - 1);
  localparam logic [7:0]     CFG_CMD     = {2'b00, CFG_ADDR[5:0]};
  localparam logic [7:0]     RD_CMD_BYTE = {2'b11, DATA_ADDR[5:0]};
  localparam logic [2:0]     LAST_IDX    = 3'd5;

  typedef enum logic [2:0] {CFG_ADDR_S, CFG_DATA_S, IDLE, RD_CMD, RD_BYTE, PUBLISH} state_t;

  state_t          state, state_nx;
  logic            wait_ph, wait_nx;
  logic [2:0]      idx, idx_nx;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic            pend;
  logic [4:0][7:0] sb;

  logic       start_nx, hold_nx, issue_hold;
  logic [7:0] tx_nx, issue_byte;
  logic       sb_we, pub, cfg_set, cfg_clr, svc;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CFG_ADDR_S;
      wait_ph <= 1'b0;
      idx     <= 3'd0;
    end else begin
      state   <= state_nx;
      wait_ph <= wait_nx;
      idx     <= idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    wait_nx    = wait_ph;
    idx_nx     = idx;
    start_nx   = 1'b0;
    tx_nx      = spi.spi_tx_byte;
    hold_nx    = spi.spi_hold;
    sb_we      = 1'b0;
    pub        = 1'b0;
    cfg_set    = 1'b0;
    cfg_clr    = 1'b0;
    svc        = 1'b0;
    issue_byte = 8'h00;
    issue_hold = 1'b0;

    case (state)
      CFG_ADDR_S: begin issue_byte = CFG_CMD;     issue_hold = 1'b1; end
      CFG_DATA_S: begin issue_byte = CFG_DATA;    issue_hold = 1'b0; end
      RD_CMD:     begin issue_byte = RD_CMD_BYTE; issue_hold = 1'b1; end
      RD_BYTE:    begin issue_byte = 8'h00;       issue_hold = (idx != LAST_IDX); end
      default:    ;
    endcase

    case (state)
      IDLE: begin
        if (reconfig || pend) begin
          svc      = 1'b1;
          cfg_clr  = 1'b1;
          state_nx = CFG_ADDR_S;
        end else if (tick && enable) begin
          state_nx = RD_CMD;
        end
      end
      PUBLISH: state_nx = IDLE;
      default: begin
        // ISSUE phase launches the byte; WAIT phase only reacts to spi_done
        if (!wait_ph) begin
          if (!spi.spi_busy) begin
            start_nx = 1'b1;
            tx_nx    = issue_byte;
            hold_nx  = issue_hold;
            wait_nx  = 1'b1;
          end
        end else if (spi.spi_done) begin
          wait_nx = 1'b0;
          case (state)
            CFG_ADDR_S: state_nx = CFG_DATA_S;
            CFG_DATA_S: begin state_nx = IDLE; cfg_set = 1'b1; end
            RD_CMD:     begin state_nx = RD_BYTE; idx_nx = 3'd0; end
            default: begin
              sb_we = 1'b1;
              if (idx == LAST_IDX) begin
                pub      = 1'b1;
                state_nx = PUBLISH;
              end else begin
                idx_nx = idx + 3'd1;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt             <= '0;
      pend            <= 1'b0;
      cfg_done        <= 1'b0;
      overrun         <= 1'b0;
      spi.spi_start   <= 1'b0;
      spi.spi_tx_byte <= 8'h00;
      spi.spi_hold    <= 1'b0;
      sb              <= '0;
      accel_x         <= 16'h0000;
      accel_y         <= 16'h0000;
      accel_z         <= 16'h0000;
      sample_valid    <= 1'b0;
    end else begin
      cnt             <= tick ? '0 : cnt + 1'b1;
      spi.spi_start   <= start_nx;
      spi.spi_tx_byte <= tx_nx;
      spi.spi_hold    <= hold_nx;
      sample_valid    <= pub;

      if (svc)           pend <= 1'b0;
      else if (reconfig) pend <= 1'b1;

      if (cfg_clr)      cfg_done <= 1'b0;
      else if (cfg_set) cfg_done <= 1'b1;

      if (tick && state != IDLE) overrun <= 1'b1;

      if (sb_we && idx != LAST_IDX) sb[idx] <= spi.spi_rx_byte;

      // Z high byte comes straight off the wire so the strobe lands one cycle after the last spi_done
      if (pub) begin
        accel_x <= {sb[1], sb[0]};
        accel_y <= {sb[3], sb[2]};
        accel_z <= {spi.spi_rx_byte, sb[4]};
      end
    end
  end

endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Bench for accel_poll_sequencer with a behavioural byte-level SPI master of programmable done delay.
module tb_accel_poll_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        reconfig;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, cfg_done, overrun;

  accel_poll_sequencer_if spi_bus ();

  accel_poll_sequencer #(.POLL_DIV(64)) dut (
    .clk(clk), .reset(reset), .enable(enable), .reconfig(reconfig), .spi(spi_bus),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .cfg_done(cfg_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    logic       hold;
  } vec_t;
  vec_t rd_tab [7];

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_log[$];
  logic       hold_log[$];
  logic [7:0] resp_q[$];
  int dly = 8;

  int cyc = 0, last_done_cyc = 0, sv_cnt = 0, sv_lat = 0, sv_wide = 0;
  int start_cnt = 0, viol = 0, cfg_rise_lat = 0, cfg_fall = 0;
  logic prev_sv = 1'b0, prev_cfg = 1'b0;

  // SPI master model: busy from the cycle after spi_start, done pulse dly cycles after spi_start
  logic st;
  bit   active;
  int   mcnt;
  initial begin
    spi_bus.spi_busy    = 1'b0;
    spi_bus.spi_done    = 1'b0;
    spi_bus.spi_rx_byte = 8'h00;
    active = 0;
    mcnt   = 0;
    forever begin
      @(negedge clk);
      st = spi_bus.spi_start;
      if (st && !reset) begin
        tx_log.push_back(spi_bus.spi_tx_byte);
        hold_log.push_back(spi_bus.spi_hold);
      end
      @(posedge clk);
      #1;
      spi_bus.spi_done = 1'b0;
      if (reset) begin
        active = 0;
        spi_bus.spi_busy = 1'b0;
      end else if (active) begin
        mcnt++;
        if (mcnt >= dly) begin
          spi_bus.spi_done    = 1'b1;
          spi_bus.spi_busy    = 1'b0;
          spi_bus.spi_rx_byte = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h5A;
          active = 0;
        end
      end else if (st) begin
        active = 1;
        mcnt   = 1;
        spi_bus.spi_busy = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (spi_bus.spi_done) last_done_cyc = cyc;
      if (sample_valid) begin
        sv_cnt++;
        sv_lat = cyc - last_done_cyc;
        if (prev_sv) sv_wide++;
      end
      prev_sv = sample_valid;
      if (spi_bus.spi_start) start_cnt++;
      if (spi_bus.spi_start && spi_bus.spi_busy) viol++;
      if (cfg_done && !prev_cfg) cfg_rise_lat = cyc - last_done_cyc;
      if (!cfg_done && prev_cfg) cfg_fall++;
      prev_cfg = cfg_done;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] tx_at(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 8'hxx;
  endfunction

  function automatic logic hold_at(input int i);
    return (i < hold_log.size()) ? hold_log[i] : 1'bx;
  endfunction

  task automatic wait_sv(input int maxc, input string nm);
    int  base = sv_cnt;
    bit  ok = 0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (sv_cnt > base) begin ok = 1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_cfg(input int maxc, input string nm);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (cfg_done === 1'b1) begin ok = 1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_log(input int n, input int maxc, input string nm);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (tx_log.size() >= n) begin ok = 1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic start_frame(input int d);
    dly = d;
    tx_log.delete();
    hold_log.delete();
    resp_q.delete();
    for (int i = 0; i < 7; i++) resp_q.push_back(rd_tab[i].rx);
    enable = 1'b1;
  endtask

  task automatic chk_sample(input string tag);
    chk({tag, "_x"}, 32'(accel_x), 32'h1234);
    chk({tag, "_y"}, 32'(accel_y), 32'hABCD);
    chk({tag, "_z"}, 32'(accel_z), 32'hFFFE);
  endtask

  int base;

  initial begin
    rd_tab[0] = '{8'h00, 8'hE8, 1'b1};
    rd_tab[1] = '{8'h34, 8'h00, 1'b1};
    rd_tab[2] = '{8'h12, 8'h00, 1'b1};
    rd_tab[3] = '{8'hCD, 8'h00, 1'b1};
    rd_tab[4] = '{8'hAB, 8'h00, 1'b1};
    rd_tab[5] = '{8'hFE, 8'h00, 1'b1};
    rd_tab[6] = '{8'hFF, 8'h00, 1'b0};

    reset = 1'b1; enable = 1'b0; reconfig = 1'b0; dly = 8;
    repeat (3) step();
    chk("rst_start", 32'(spi_bus.spi_start), 32'd0);
    chk("rst_tx", 32'(spi_bus.spi_tx_byte), 32'h00);
    chk("rst_hold", 32'(spi_bus.spi_hold), 32'd0);
    chk("rst_x", 32'(accel_x), 32'd0);
    chk("rst_sv", 32'(sample_valid), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // config write, first spi_start on the first edge after release
    reset = 1'b0;
    step();
    chk("first_start", 32'(spi_bus.spi_start), 32'd1);
    chk("first_tx", 32'(spi_bus.spi_tx_byte), 32'h20);
    wait_cfg(200, "cfg_wait");
    chk("cfg_nbytes", tx_log.size(), 32'd2);
    chk("cfg_tx0", 32'(tx_at(0)), 32'h20);
    chk("cfg_hold0", 32'(hold_at(0)), 32'd1);
    chk("cfg_tx1", 32'(tx_at(1)), 32'h47);
    chk("cfg_hold1", 32'(hold_at(1)), 32'd0);
    chk("cfg_done_lat", cfg_rise_lat, 32'd1);

    // enable low across five ticks: silent
    base = start_cnt;
    repeat (5 * 64 + 10) step();
    chk("dis_no_start", start_cnt, base);
    chk("dis_overrun", 32'(overrun), 32'd0);

    // normal burst read
    base = sv_cnt;
    start_frame(4);
    wait_sv(200, "rd_sv_wait");
    enable = 1'b0;
    repeat (5) step();
    chk("rd_nbytes", tx_log.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("rd_tx%0d", i), 32'(tx_at(i)), 32'(rd_tab[i].tx));
      chk($sformatf("rd_hold%0d", i), 32'(hold_at(i)), 32'(rd_tab[i].hold));
    end
    chk_sample("rd");
    chk("rd_sv_count", sv_cnt - base, 32'd1);
    chk("rd_sv_lat", sv_lat, 32'd1);
    chk("rd_overrun", 32'(overrun), 32'd0);

    // reconfig during RD_BYTE index 3, twice: one extra config write after the publish
    base = cfg_fall;
    start_frame(4);
    wait_log(5, 200, "rc_idx3_wait");
    reconfig = 1'b1; step(); reconfig = 1'b0;
    step(); step();
    reconfig = 1'b1; step(); reconfig = 1'b0;
    wait_sv(100, "rc_sv_wait");
    chk_sample("rc");
    repeat (3) step();
    chk("rc_cfg_low", 32'(cfg_done), 32'd0);
    wait_cfg(100, "rc_cfg_wait");
    enable = 1'b0;
    chk("rc_nbytes", tx_log.size(), 32'd9);
    chk("rc_tx7", 32'(tx_at(7)), 32'h20);
    chk("rc_hold7", 32'(hold_at(7)), 32'd1);
    chk("rc_tx8", 32'(tx_at(8)), 32'h47);
    chk("rc_hold8", 32'(hold_at(8)), 32'd0);
    repeat (20) step();
    chk("rc_collapse", tx_log.size(), 32'd9);
    chk("rc_fall_count", cfg_fall - base, 32'd1);
    chk("rc_overrun", 32'(overrun), 32'd0);

    // slow SPI master: later ticks land mid-frame
    start_frame(20);
    wait_sv(400, "ov_sv_wait");
    enable = 1'b0;
    chk_sample("ov");
    chk("ov_set", 32'(overrun), 32'd1);
    repeat (70) step();
    chk("ov_sticky", 32'(overrun), 32'd1);

    // reset after the fourth read byte
    start_frame(4);
    begin
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
        step();
        if (resp_q.size() <= 2) begin ok = 1; break; end
      end
      chk("mr_byte4_wait", 32'(ok), 32'd1);
    end
    base = sv_cnt;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("mr_x", 32'(accel_x), 32'd0);
    chk("mr_y", 32'(accel_y), 32'd0);
    chk("mr_z", 32'(accel_z), 32'd0);
    chk("mr_cfg_done", 32'(cfg_done), 32'd0);
    chk("mr_overrun", 32'(overrun), 32'd0);
    chk("mr_hold", 32'(spi_bus.spi_hold), 32'd0);
    chk("mr_start", 32'(spi_bus.spi_start), 32'd0);
    enable = 1'b0;
    resp_q.delete();
    repeat (3) step();
    tx_log.delete();
    hold_log.delete();
    reset = 1'b0;
    wait_cfg(200, "mr_cfg_wait");
    repeat (5) step();
    chk("mr_no_sv", sv_cnt - base, 32'd0);
    chk("mr_nbytes", tx_log.size(), 32'd2);
    chk("mr_tx0", 32'(tx_at(0)), 32'h20);
    chk("mr_tx1", 32'(tx_at(1)), 32'h47);

    chk("start_while_busy", viol, 32'd0);
    chk("sv_single_cycle", sv_wide, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_poll_sequencer.md
# accel_poll_sequencer

Transaction sequencer that sits directly upstream of the byte-level SPI master. After reset it writes one configuration register in the accelerometer. It then polls the six axis output registers at a fixed rate in a single burst read and assembles the bytes into signed 16-bit X/Y/Z samples. These are presented to downstream logic with a one-cycle valid strobe.

## Interface
Parameters:
- POLL_DIV, 1000: clk cycles between poll ticks (≥ 2).
- CFG_ADDR, 8'h20: configuration register address.
- CFG_DATA, 8'h47: configuration value written after reset or reconfig.
- DATA_ADDR, 8'h28: first axis register (X_L); X_L, X_H, Y_L, Y_H, Z_L, Z_H are consecutive.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  system clock.
  - reset  in  1  asynchronous, active-high reset.
- Control:
  - enable  in  1  polling allowed when high; the config write runs regardless.
  - reconfig  in  1  one-cycle request to repeat the config write.
- SPI master interface:
  - spi_busy  in  1  SPI master is transferring a byte.
  - spi_done  in  1  one-cycle pulse marking the end of a byte; spi_rx_byte is valid.
  - spi_rx_byte  in  8  byte shifted in from MISO.
  - spi_start  out  1  one-cycle request to transfer spi_tx_byte.
  - spi_tx_byte  out  8  byte to shift out on MOSI.
  - spi_hold  out  1  keep CS asserted after the current byte (multi-byte frame).
- Sample outputs:
  - accel_x, accel_y, accel_z  out  16 each  latest sample, {H,L}.
  - sample_valid  out  1  one-cycle strobe when new X/Y/Z are valid.
  - cfg_done  out  1  high once the config write has completed.
  - overrun  out  1  sticky; a poll tick arrived while a read was in progress.

## Operation
- States: CFG_ADDR_S, CFG_DATA_S, IDLE, RD_CMD, RD_BYTE, PUBLISH.
  - Each byte-issuing state has two phases:
    - ISSUE: wait for spi_busy low, then assert spi_start for exactly one cycle with spi_tx_byte stable.
    - WAIT: wait for spi_done.
- Config write:
  - After reset, enter CFG_ADDR_S and send {1'b0,1'b0,CFG_ADDR[5:0]} with spi_hold=1.
  - CFG_DATA_S: send CFG_DATA with spi_hold=0.
  - On its spi_done, set cfg_done=1 and go to IDLE.
- Poll counter:
  - Free-running; counts 0..POLL_DIV-1 from reset.
  - Generates tick on the cycle it wraps to 0.
  - Runs in every state.
- IDLE:
  - A pending reconfig takes priority: clear cfg_done and go to CFG_ADDR_S.
  - Otherwise, on tick with enable=1, go to RD_CMD.
  - A tick with enable=0 is ignored silently.
- RD_CMD:
  - Send {1'b1 read, 1'b1 auto-increment, DATA_ADDR[5:0]} (8'hE8 for the default) with spi_hold=1.
  - Discard the received byte.
- RD_BYTE:
  - Six transfers of 8'h00, index 0..5.
  - spi_hold=1 for indices 0..4 and 0 for index 5.
  - On each spi_done, store spi_rx_byte in shadow byte[index].
- PUBLISH (one cycle):
  - accel_x={b1,b0}, accel_y={b3,b2}, accel_z={b5,b4}.
  - sample_valid=1; return to IDLE.
  - The outputs hold their value until the next PUBLISH.
- Boundary and corner cases:
  - reconfig outside IDLE is latched as pending and serviced at the next IDLE. Multiple requests collapse into one.
  - A tick in any state other than IDLE sets overrun=1; the tick is dropped and not queued. Only reset clears overrun.
  - Reset at any point, including mid-frame: all outputs return to reset values immediately and the sequence restarts at CFG_ADDR_S. Partial shadow bytes are never published.
  - spi_done while not in a WAIT phase is ignored.

## Timing
- Reset values:
  - spi_start=0, spi_tx_byte=8'h00, spi_hold=0.
  - accel_x/y/z=16'h0000, sample_valid=0, cfg_done=0, overrun=0.
  - poll counter=0, pending reconfig=0.
- First spi_start: the first clk edge after reset deasserts, provided spi_busy=0.
- spi_start handshake:
  - Next spi_start comes no earlier than the cycle after spi_done.
  - spi_start is never asserted while spi_busy=1.
- spi_tx_byte and spi_hold are registered. They are valid in the spi_start cycle and held stable until spi_done.
- Read frame: 7 spi_start pulses.
- sample_valid latency: exactly one cycle after the 7th spi_done; it is registered and high for 1 cycle.
- Tick to RD_CMD: 1 cycle. Tick to first spi_start: ≤ 2 cycles when spi_busy=0.

## Test plan
- Reset release with an SPI master model (done 8 cycles after start):
  - Expect bytes 8'h20 (hold=1) then 8'h47 (hold=0).
  - cfg_done rises the cycle after the 2nd spi_done.
  - No read before that.
- enable=1, POLL_DIV=64, model returns 00,34,12,CD,AB,FE,FF on the 7 bytes:
  - Expect tx E8,00×6 with hold 1,1,1,1,1,1,0.
  - accel_x=16'h1234, accel_y=16'hABCD, accel_z=16'hFFFE.
  - sample_valid is a single pulse.
- SPI master done delay 20 cycles, POLL_DIV=64: the second tick lands mid-frame → overrun=1 and stays 1; the frame completes with correct data.
- reconfig pulse during RD_BYTE index 3:
  - The read completes and publishes.
  - Then cfg_done drops and 20/47 is re-sent before the next poll.
- Reset asserted after the 4th read byte:
  - Outputs return to 0 asynchronously; no sample_valid.
  - Config restarts after release.
- enable=0 across 5 ticks: no spi_start after config, overrun stays 0.
